rv32_lsu: RTL and testbench

Load/store unit on the memory side of the execute stage. It takes the effective address produced by the ALU, plus the store data and width/sign selection, and runs a request/grant/response handshake to data memory. It generates byte enables and lane-replicated store data, and extracts and sign/zero-extends load data for the writeback mux. Misaligned or illegal accesses are flagged instead of being issued to memory.

---
 rtl/rv32_lsu.sv | 144 ++++++++++++++
 tb/tb_rv32_lsu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_lsu.sv
// RV32I load/store unit: request/grant/response handshake to data memory,
// byte-lane steering for stores and sign/zero extension for loads.
module rv32_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_req_t;

  state_t          state;
  lsu_req_t        cur;
  logic            misalign, illegal, req_err, sgn;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n, shifted, load_ext;

  // Decode of the incoming request; only consumed in IDLE.
  always_comb begin
    misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    illegal  = req_is_store ? (req_funct3 != 3'b000 && req_funct3 != 3'b001 &&
                               req_funct3 != 3'b010)
                            : (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                               req_funct3 == 3'b111);
    req_err  = misalign || illegal;
    case (req_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << req_addr[1:0];
        wdata_n = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << req_addr[1:0];
        wdata_n = {2{req_wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = req_wdata;
      end
    endcase
  end

  // Load extraction uses the captured funct3/offset, not the live request.
  always_comb begin
    shifted = mem_rdata >> {cur.off, 3'b000};
    sgn     = !cur.funct3[2];
    case (cur.funct3[1:0])
      2'b00:   load_ext = {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cur.is_store <= req_is_store;
          cur.funct3   <= req_funct3;
          cur.off      <= req_addr[1:0];
          req_ready    <= 1'b0;
          if (req_err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= req_is_store;
            mem_be    <= be_n;
            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
            mem_wdata <= req_is_store ? wdata_n : '0;
          end
        end
        REQ: if (mem_gnt) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= '0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (cur.is_store) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (mem_rvalid) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_ext;
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed bench for rv32_lsu: transaction-level reference model checked every
// cycle, plus literal expectations for the hand-worked vectors.
module tb_rv32_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  rv32_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference rules stated as plain arithmetic on access size and offset.
  function automatic void ref_access(input logic st, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     input logic [31:0] rw, output logic err,
                                     output logic [3:0] be, output logic [31:0] mwd,
                                     output logic [31:0] rd);
    int          sz;
    logic [31:0] mask, sh;
    sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err  = (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
           ((int'(a[1:0]) % sz) != 0);
    be   = 4'(((1 << sz) - 1) << a[1:0]);
    mwd  = (sz == 1) ? wd[7:0] * 32'h01010101 :
           (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
    mask = (sz == 4) ? 32'hFFFFFFFF : 32'((64'd1 << (8 * sz)) - 64'd1);
    sh   = rw >> (8 * a[1:0]);
    rd   = sh & mask;
    if (!f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | ~mask;
  endfunction

  // Transaction model: one outstanding access, advanced from sampled inputs.
  bit          m_on = 0, pend = 0, m_done = 0;
  bit          t_st, t_err, granted, got;
  logic [2:0]  t_f3;
  logic [31:0] t_a, e_addr, e_wd, e_rd, d_wd, d_rd;
  logic [3:0]  e_be, d_be;
  logic        d_err;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend = 0;
      m_on = 1;
    end else if (pend) begin
      if (m_done) pend = 0;
      else begin
        if (granted && !t_st && !got && mem_rvalid) begin
          got = 1;
          ref_access(t_st, t_f3, t_a, 32'h0, mem_rdata, d_err, d_be, d_wd, e_rd);
        end
        if (!granted && !t_err && mem_gnt) granted = 1;
      end
    end else if (req_valid) begin
      pend    = 1;
      t_st    = req_is_store;
      t_f3    = req_funct3;
      t_a     = req_addr;
      granted = 0;
      got     = 0;
      e_rd    = 32'h0;
      e_addr  = {req_addr[31:2], 2'b00};
      ref_access(req_is_store, req_funct3, req_addr, req_wdata, 32'h0, t_err, e_be, e_wd, d_rd);
    end
    m_done = pend && (t_err || (granted && (t_st || got)));
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("req_ready", req_ready, !pend);
      chk("mem_req", mem_req, pend && !t_err && !granted);
      if (pend && !t_err && !granted) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", mem_be, e_be);
        chk("mem_we", mem_we, t_st);
        if (t_st) chk("mem_wdata", mem_wdata, e_wd);
      end
      chk("resp_valid", resp_valid, m_done);
      if (m_done) begin
        chk("resp_err", resp_err, t_err);
        chk("resp_rdata", resp_rdata, e_rd);
      end
    end
  end

  // Snapshot of the request phase of the last transaction.
  bit          snap_seen, unstable;
  int          req_cycles;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        snap_we;

  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int gwait,
                         output logic [31:0] rd, output logic er, output int lat);
    int waited;
    int c0;
    bit rv_pend;
    waited = 0; rv_pend = 0; lat = -1; rd = '0; er = 1'b0;
    snap_seen = 0; unstable = 0; req_cycles = 0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 60; i++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD0000;
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err; lat = cyc - c0 + 1;
        break;
      end
      if (rv_pend) begin
        mem_rvalid = 1'b1; mem_rdata = rw; rv_pend = 0;
      end
      if (mem_req) begin
        if (!snap_seen) begin
          snap_seen = 1; snap_addr = mem_addr; snap_be = mem_be;
          snap_we = mem_we; snap_wdata = mem_wdata;
        end else if (mem_addr !== snap_addr || mem_be !== snap_be ||
                     mem_we !== snap_we || mem_wdata !== snap_wdata) begin
          unstable = 1;
        end
        req_cycles++;
        if (waited >= gwait) begin
          mem_gnt = 1'b1;
          if (!st) rv_pend = 1;
        end else waited++;
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout: no resp_valid for addr %h within 60 cycles", a);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    run_txn(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, rd, er, lat);
    chk("sw_addr", snap_addr, 32'h100);
    chk("sw_be", snap_be, 4'b1111);
    chk("sw_we", snap_we, 1);
    chk("sw_wdata", snap_wdata, 32'hDEADBEEF);
    chk("sw_lat", lat, 2);
    chk("sw_err", er, 0);

    run_txn(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, rd, er, lat);
    chk("sb_be", snap_be, 4'b1000);
    chk("sb_wdata", snap_wdata, 32'hA5A5A5A5);
    chk("sb_addr", snap_addr, 32'h100);

    run_txn(1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, rd, er, lat);
    chk("sh_be", snap_be, 4'b1100);
    chk("sh_wdata", snap_wdata, 32'hABCDABCD);

    run_txn(0, 3'b000, 32'h201, 0, 32'h12348067, 0, rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    chk("lb_lat", lat, 3);
    chk("lb_be", snap_be, 4'b0010);
    chk("lb_we", snap_we, 0);
    run_txn(0, 3'b100, 32'h201, 0, 32'h12348067, 0, rd, er, lat);
    chk("lbu_rdata", rd, 32'h00000080);
    run_txn(0, 3'b101, 32'h202, 0, 32'h12348067, 0, rd, er, lat);
    chk("lhu_rdata", rd, 32'h00001234);
    run_txn(0, 3'b001, 32'h200, 0, 32'h00008001, 1, rd, er, lat);
    chk("lh_rdata", rd, 32'hFFFF8001);
    run_txn(0, 3'b010, 32'h204, 0, 32'hCAFEF00D, 0, rd, er, lat);
    chk("lw_rdata", rd, 32'hCAFEF00D);

    run_txn(0, 3'b010, 32'h302, 0, 32'h11111111, 0, rd, er, lat);
    chk("lw_mis_err", er, 1);
    chk("lw_mis_rdata", rd, 0);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_no_req", snap_seen, 0);
    run_txn(0, 3'b011, 32'h300, 0, 32'h11111111, 0, rd, er, lat);
    chk("ld011_err", er, 1);
    chk("ld011_lat", lat, 1);
    chk("ld011_no_req", snap_seen, 0);
    run_txn(1, 3'b100, 32'h300, 32'h55, 0, 0, rd, er, lat);
    chk("st100_err", er, 1);
    run_txn(1, 3'b001, 32'h101, 32'h55, 0, 0, rd, er, lat);
    chk("sh_mis_err", er, 1);

    run_txn(1, 3'b010, 32'h104, 32'h0BADF00D, 0, 5, rd, er, lat);
    chk("gnt5_req_cycles", req_cycles, 6);
    chk("gnt5_stable", unstable, 0);
    chk("gnt5_lat", lat, 7);
    chk("gnt5_err", er, 0);

    // Reset while a load waits for data, followed by a stray rvalid.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("abort_wait_req", mem_req, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h87654321;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("abort_ready", req_ready, 1);
      chk("abort_resp_valid", resp_valid, 0);
      chk("abort_resp_rdata", resp_rdata, 0);
      chk("abort_mem_req", mem_req, 0);
      chk("abort_mem_be", mem_be, 0);
      chk("abort_mem_addr", mem_addr, 0);
      @(negedge clk);
    end

    run_txn(0, 3'b000, 32'h403, 0, 32'h7F000000, 0, rd, er, lat);
    chk("post_rst_lb", rd, 32'h0000007F);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
